// File: rtl/am2909_next_address_control_if.sv
// Bus between the next-address control unit (master) and the ROM/Am2909 side (slave).
// WORD_W must match the parameter of the attached am2909_next_address_control.
interface am2909_next_address_control_if #(
    parameter int unsigned WORD_W = 16
);
    localparam int unsigned FW = WORD_W - 8;

    logic [WORD_W-1:0] uword_in;
    logic              hold;
    logic [3:0]        cond;
    logic [WORD_W-1:0] uword;
    logic [FW-1:0]     d;
    logic [1:0]        s;
    logic              fe_n;
    logic              pup;
    logic              re_n;
    logic              zero_n;
    logic              cn;
    logic              cnt_zero;
    logic              stk_err;

    modport master (
        input  uword_in, hold, cond,
        output uword, d, s, fe_n, pup, re_n, zero_n, cn, cnt_zero, stk_err
    );

    modport slave (
        output uword_in, hold, cond,
        input  uword, d, s, fe_n, pup, re_n, zero_n, cn, cnt_zero, stk_err
    );
endinterface

// File: rtl/am2909_next_address_control.sv
// Microinstruction pipeline register and next-address decode driving an Am2909 sequencer.
// Optional stack depth guard enabled by defining NAC_STACK_GUARD_EN.
module am2909_next_address_control #(
    parameter int unsigned WORD_W = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    am2909_next_address_control_if.master  nac_io
);
    localparam int unsigned FW = WORD_W - 8;

    typedef enum logic [3:0] {
        OpJz   = 4'd0,
        OpCjp  = 4'd1,
        OpCjs  = 4'd2,
        OpCrtn = 4'd3,
        OpLdct = 4'd4,
        OpRpct = 4'd5,
        OpLdar = 4'd6,
        OpJrp  = 4'd7
    } op_e;

    logic [WORD_W-1:0] uword_q, uword_d;
    logic [3:0]        status_q, status_d;
    logic [FW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     field;
    logic              pass;
    logic              push, pop, stk_bad;
    logic [1:0]        s_dec;
    logic              pup_dec, re_n_dec, zero_n_dec;

    assign field = uword_q[WORD_W-1:8];
    assign pass  = status_q[uword_q[5:4]] ^ uword_q[6];

    always_comb begin
        s_dec      = 2'b00;
        pup_dec    = 1'b0;
        re_n_dec   = 1'b1;
        zero_n_dec = 1'b1;
        push       = 1'b0;
        pop        = 1'b0;
        cnt_d      = cnt_q;
        case (op_e'(uword_q[3:0]))
            OpJz:   zero_n_dec = 1'b0;
            OpCjp:  if (pass) s_dec = 2'b11;
            OpCjs:  if (pass) begin s_dec = 2'b11; push = 1'b1; pup_dec = 1'b1; end
            OpCrtn: if (pass) begin s_dec = 2'b10; pop = 1'b1; end
            OpLdct: cnt_d = field;
            OpRpct: begin
                // Saturates at zero so a count of 0 falls straight through.
                if (cnt_q != '0) begin
                    s_dec = 2'b11;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OpLdar: re_n_dec = 1'b0;
            OpJrp:  s_dec = pass ? 2'b11 : 2'b01;
            default: ;
        endcase
    end

`ifdef NAC_STACK_GUARD_EN
    logic [2:0] depth_q, depth_d;
    logic       stk_err_q, stk_err_d;

    assign stk_bad = (push && depth_q == 3'd4) || (pop && depth_q == 3'd0);

    always_comb begin
        depth_d   = depth_q;
        stk_err_d = stk_err_q;
        if (!nac_io.hold) begin
            if (stk_bad) begin
                stk_err_d = 1'b1;
            end else if (push) begin
                depth_d = depth_q + 3'd1;
            end else if (pop) begin
                depth_d = depth_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            depth_q   <= 3'd0;
            stk_err_q <= 1'b0;
        end else begin
            depth_q   <= depth_d;
            stk_err_q <= stk_err_d;
        end
    end

    assign nac_io.stk_err = stk_err_q;
`else
    assign stk_bad        = 1'b0;
    assign nac_io.stk_err = 1'b0;
`endif

    always_comb begin
        uword_d  = uword_q;
        status_d = status_q;
        if (!nac_io.hold) begin
            uword_d = nac_io.uword_in;
            if (uword_q[7]) status_d = nac_io.cond;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            uword_q  <= '0;
            status_q <= '0;
            cnt_q    <= '0;
        end else if (!nac_io.hold) begin
            uword_q  <= uword_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    // Hold makes the sequencer re-issue its current address: uPC source, no carry-in.
    always_comb begin
        nac_io.s      = stk_bad ? 2'b00 : s_dec;
        nac_io.fe_n   = !((push || pop) && !stk_bad);
        nac_io.pup    = pup_dec;
        nac_io.re_n   = re_n_dec;
        nac_io.zero_n = zero_n_dec;
        nac_io.cn     = 1'b1;
        if (nac_io.hold) begin
            nac_io.s      = 2'b00;
            nac_io.fe_n   = 1'b1;
            nac_io.re_n   = 1'b1;
            nac_io.zero_n = 1'b1;
            nac_io.cn     = 1'b0;
        end
    end

    assign nac_io.uword    = uword_q;
    assign nac_io.d        = field;
    assign nac_io.cnt_zero = (cnt_q == '0);

endmodule

// File: tb/tb_am2909_next_address_control.sv
// Randomised and directed checks of am2909_next_address_control against a behavioural model.
// Define NAC_STACK_GUARD_EN for both RTL and bench to exercise the stack guard.
module tb_am2909_next_address_control;
    localparam int unsigned WORD_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    am2909_next_address_control_if #(.WORD_W(WORD_W)) nac ();

    am2909_next_address_control #(.WORD_W(WORD_W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .nac_io (nac)
    );

    // Reference state
    logic [15:0] m_uword;
    logic [3:0]  m_status;
    int          m_cnt;
    int          m_depth;
    logic        m_err;

    // Expected outputs
    logic [1:0] e_s;
    logic       e_fe_n, e_pup, e_re_n, e_zero_n, e_cn;
    logic       e_push, e_pop, e_bad;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_uword  = '0;
        m_status = '0;
        m_cnt    = 0;
        m_depth  = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_eval(input logic hold);
        int  op;
        bit  pass;
        op   = int'(m_uword[3:0]);
        pass = (m_status[m_uword[5:4]] != m_uword[6]);
        e_s = 2'b00; e_fe_n = 1'b1; e_pup = 1'b0; e_re_n = 1'b1; e_zero_n = 1'b1; e_cn = 1'b1;
        e_push = 1'b0; e_pop = 1'b0; e_bad = 1'b0;
        if (op == 0) e_zero_n = 1'b0;
        if (op == 1 && pass) e_s = 2'b11;
        if (op == 2 && pass) begin e_s = 2'b11; e_push = 1'b1; e_pup = 1'b1; end
        if (op == 3 && pass) begin e_s = 2'b10; e_pop = 1'b1; end
        if (op == 5 && m_cnt > 0) e_s = 2'b11;
        if (op == 6) e_re_n = 1'b0;
        if (op == 7) e_s = pass ? 2'b11 : 2'b01;
        if (e_push || e_pop) e_fe_n = 1'b0;
`ifdef NAC_STACK_GUARD_EN
        e_bad = (e_push && m_depth >= 4) || (e_pop && m_depth <= 0);
        if (e_bad) begin e_fe_n = 1'b1; e_s = 2'b00; end
`endif
        if (hold) begin
            e_s = 2'b00; e_fe_n = 1'b1; e_re_n = 1'b1; e_zero_n = 1'b1; e_cn = 1'b0;
        end
    endtask

    task automatic model_step(input logic [15:0] w, input logic hold, input logic [3:0] c);
        int op;
        model_eval(hold);
        if (hold) return;
        op = int'(m_uword[3:0]);
        if (op == 4) m_cnt = int'(m_uword[15:8]);
        else if (op == 5 && m_cnt > 0) m_cnt = m_cnt - 1;
`ifdef NAC_STACK_GUARD_EN
        if (e_bad) m_err = 1'b1;
        else if (e_push) m_depth++;
        else if (e_pop) m_depth--;
`endif
        if (m_uword[7]) m_status = c;
        m_uword = w;
    endtask

    task automatic compare();
        model_eval(nac.hold);
        check_eq("uword", 32'(nac.uword), 32'(m_uword));
        check_eq("d", 32'(nac.d), 32'(m_uword[15:8]));
        check_eq("s", 32'(nac.s), 32'(e_s));
        check_eq("fe_n", 32'(nac.fe_n), 32'(e_fe_n));
        if (!e_fe_n) check_eq("pup", 32'(nac.pup), 32'(e_pup));
        check_eq("re_n", 32'(nac.re_n), 32'(e_re_n));
        check_eq("zero_n", 32'(nac.zero_n), 32'(e_zero_n));
        check_eq("cn", 32'(nac.cn), 32'(e_cn));
        check_eq("cnt_zero", 32'(nac.cnt_zero), 32'(m_cnt == 0));
        check_eq("stk_err", 32'(nac.stk_err), 32'(m_err));
    endtask

    // Inputs applied just after a rising edge, checked on the falling edge.
    task automatic cycle(input logic [15:0] w, input logic h, input logic [3:0] c);
        nac.uword_in = w;
        nac.hold     = h;
        nac.cond     = c;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step(w, h, c);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        compare();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] w;
        nac.uword_in = '0;
        nac.hold     = 1'b0;
        nac.cond     = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reset decode is JZ
        check_eq("t1_s", 32'(nac.s), 32'd0);
        check_eq("t1_zero_n", 32'(nac.zero_n), 32'd0);
        check_eq("t1_cn", 32'(nac.cn), 32'd1);
        check_eq("t1_cnt_zero", 32'(nac.cnt_zero), 32'd1);
        cycle(16'h0000, 1'b0, 4'h0);
        check_eq("t1_uword", 32'(nac.uword), 32'd0);

        // Conditional jump, both polarities
        cycle(16'h0380, 1'b0, 4'b0001);
        cycle(16'h2501, 1'b0, 4'b0001);
        check_eq("t2_s_pass", 32'(nac.s), 32'h3);
        check_eq("t2_d", 32'(nac.d), 32'h25);
        cycle(16'h2541, 1'b0, 4'b0001);
        check_eq("t2_s_fail", 32'(nac.s), 32'h0);

        // Loop counter
        cycle(16'h0304, 1'b0, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0005, 1'b0, 4'b0001);
            check_eq("t3_s", 32'(nac.s), (i < 3) ? 32'h3 : 32'h0);
            check_eq("t3_cnt_zero", 32'(nac.cnt_zero), (i < 3) ? 32'd0 : 32'd1);
        end

        // Subroutine call and return
        cycle(16'h0002, 1'b0, 4'b0001);
        check_eq("t4_cjs_fe_n", 32'(nac.fe_n), 32'd0);
        check_eq("t4_cjs_pup", 32'(nac.pup), 32'd1);
        check_eq("t4_cjs_s", 32'(nac.s), 32'h3);
        cycle(16'h0003, 1'b0, 4'b0001);
        check_eq("t4_crtn_fe_n", 32'(nac.fe_n), 32'd0);
        check_eq("t4_crtn_pup", 32'(nac.pup), 32'd0);
        check_eq("t4_crtn_s", 32'(nac.s), 32'h2);

        // Hold freezes RPCT at count 2
        cycle(16'h0204, 1'b0, 4'b0001);
        cycle(16'h0005, 1'b0, 4'b0001);
        cycle(16'h0000, 1'b1, 4'b0001);
        cycle(16'h0000, 1'b1, 4'b0001);
        check_eq("t5_s", 32'(nac.s), 32'h0);
        check_eq("t5_cn", 32'(nac.cn), 32'd0);
        check_eq("t5_uword", 32'(nac.uword), 32'h0005);
        cycle(16'h0005, 1'b0, 4'b0001);
        cycle(16'h0005, 1'b0, 4'b0001);
        cycle(16'h0000, 1'b0, 4'b0001);
        check_eq("t5_resume", 32'(nac.cnt_zero), 32'd1);

`ifdef NAC_STACK_GUARD_EN
        do_reset();
        cycle(16'h0380, 1'b0, 4'b0001);
        for (int i = 0; i < 5; i++) cycle(16'h0002, 1'b0, 4'b0001);
        check_eq("t6_fe_n", 32'(nac.fe_n), 32'd1);
        check_eq("t6_s", 32'(nac.s), 32'h0);
        cycle(16'h0000, 1'b0, 4'b0001);
        check_eq("t6_err", 32'(nac.stk_err), 32'd1);
        do_reset();
        check_eq("t6_err_clr", 32'(nac.stk_err), 32'd0);
        cycle(16'h0380, 1'b0, 4'b0001);
        cycle(16'h0003, 1'b0, 4'b0001);
        cycle(16'h0000, 1'b0, 4'b0001);
        check_eq("t6_pop_err", 32'(nac.stk_err), 32'd1);
`endif

        // Random traffic, biased toward the defined opcodes and short counts
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                w = 16'($urandom);
                if ($urandom_range(0, 1) == 1) w[3:0] = 4'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) w[15:8] = 8'($urandom_range(0, 3));
                cycle(w, ($urandom_range(0, 7) == 0), 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
